// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer: FSM state
// encoding, register-file address constants and the bundle of pipeline
// control enables with its canned patterns.
package hazard_stall_controller_pkg;

    // Register-file addressing.
    localparam int                    REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;

    // Memory-wait counter width; covers the full legal MEM_TIMEOUT range.
    localparam int WAIT_CNT_W = 16;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_e;

    // One cycle's worth of pipeline-register control.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } pipe_ctl_t;

    // Normal flow: every stage advances, nothing is squashed.
    localparam pipe_ctl_t CTL_IDLE = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
        id_ex_write: 1'b1, id_ex_bubble: 1'b0,
        ex_mem_write: 1'b1, mem_wb_bubble: 1'b0
    };

    // Load-use: hold PC and IF/ID, push a bubble into EX.
    localparam pipe_ctl_t CTL_LOADUSE = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b1, id_ex_bubble: 1'b1,
        ex_mem_write: 1'b1, mem_wb_bubble: 1'b0
    };

    // Taken branch: redirect PC, squash the two younger instructions.
    localparam pipe_ctl_t CTL_BRANCH = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
        id_ex_write: 1'b1, id_ex_bubble: 1'b1,
        ex_mem_write: 1'b1, mem_wb_bubble: 1'b0
    };

    // Memory wait or fatal error: freeze everything up to MEM, feed WB a NOP.
    localparam pipe_ctl_t CTL_FREEZE = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b0, id_ex_bubble: 1'b0,
        ex_mem_write: 1'b0, mem_wb_bubble: 1'b1
    };

    // Held in reset: nothing fetched, every stage loads a NOP.
    localparam pipe_ctl_t CTL_RESET = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
        id_ex_write: 1'b1, id_ex_bubble: 1'b1,
        ex_mem_write: 1'b1, mem_wb_bubble: 1'b1
    };

    // True when an ID-stage source operand actually reads the EX destination.
    function automatic logic src_hit(
        input logic                  uses,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst
    );
        return uses & (src == dst);
    endfunction

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Sticks at all-ones instead of wrapping; clear has priority over inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic         at_max_s;

    // Detect the saturation point so the counter never rolls over.
    always_comb begin
        at_max_s = 1'b0;
        if (count_q == {W{1'b1}}) begin
            at_max_s = 1'b1;
        end else begin
            at_max_s = 1'b0;
        end
    end

    // Counter register: synchronous clear, otherwise increment until full.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            count_q <= {W{1'b0}};
        end else if (inc_i && !at_max_s) begin
            count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Central pipeline sequencer for the 5-stage core. Handles the hazards the
// forwarding network cannot: load-use bubbles, taken-branch squashes and
// data-memory wait freezes (with a timeout that latches a fatal error).
// Pipeline enables are combinational; counters and the error flag are
// registered.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ID_EX_memRead,
    input  logic [REG_ADDR_W-1:0] ID_EX_writeReg,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs,
    input  logic [REG_ADDR_W-1:0] IF_ID_rt,
    input  logic                  IF_ID_usesRs,
    input  logic                  IF_ID_usesRt,
    input  logic                  EX_branchTaken,
    input  logic                  EX_MEM_memAccess,
    input  logic                  dmem_ready,
    output logic                  PC_write,
    output logic                  IF_ID_write,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_write,
    output logic                  ID_EX_bubble,
    output logic                  EX_MEM_write,
    output logic                  MEM_WB_bubble,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    // Last wait count before the timeout fires.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    state_e                 state_q;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q;
    logic                   mem_timeout_q;

    logic                   memwait_s;
    logic                   loaduse_s;
    logic                   branch_s;
    pipe_ctl_t              ctl_s;
    logic                   stall_inc_s;
    logic                   flush_inc_s;

    // Raw hazard conditions seen this cycle, before priority resolution.
    always_comb begin
        memwait_s = EX_MEM_memAccess & ~dmem_ready;
        branch_s  = EX_branchTaken;
        if (ID_EX_memRead && (ID_EX_writeReg != REG_ZERO)) begin
            loaduse_s = src_hit(IF_ID_usesRs, IF_ID_rs, ID_EX_writeReg) |
                        src_hit(IF_ID_usesRt, IF_ID_rt, ID_EX_writeReg);
        end else begin
            loaduse_s = 1'b0;
        end
    end

    // Priority resolution ERR > memwait > branch > loaduse into stage controls.
    // A frozen pipeline keeps any branch/load-use in place, so it is simply
    // re-evaluated once the wait ends.
    always_comb begin
        ctl_s       = CTL_IDLE;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        if (!rst_n) begin
            ctl_s = CTL_RESET;
        end else begin
            case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    if (memwait_s) begin
                        ctl_s       = CTL_FREEZE;
                        stall_inc_s = 1'b1;
                    end else if (branch_s) begin
                        ctl_s       = CTL_BRANCH;
                        flush_inc_s = 1'b1;
                    end else if (loaduse_s) begin
                        ctl_s       = CTL_LOADUSE;
                        stall_inc_s = 1'b1;
                    end else begin
                        ctl_s = CTL_IDLE;
                    end
                end
                ST_ERR: begin
                    ctl_s = CTL_FREEZE;
                end
                default: begin
                    ctl_s = CTL_FREEZE;
                end
            endcase
        end
    end

    // Sequencer FSM: tracks memory-wait length and latches the fatal timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= {WAIT_CNT_W{1'b0}};
            mem_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (memwait_s) begin
                        state_q    <= ST_MEM_WAIT;
                        wait_cnt_q <= {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_q    <= ST_RUN;
                        wait_cnt_q <= {WAIT_CNT_W{1'b0}};
                    end
                    mem_timeout_q <= 1'b0;
                end
                ST_MEM_WAIT: begin
                    if (!memwait_s) begin
                        // Ready, or the access went away: this cycle already ran unfrozen.
                        state_q    <= ST_RUN;
                        wait_cnt_q <= {WAIT_CNT_W{1'b0}};
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q       <= ST_ERR;
                        mem_timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_ERR: begin
                    // Terminal until reset.
                    state_q       <= ST_ERR;
                    mem_timeout_q <= 1'b1;
                end
                default: begin
                    // Corrupted state encoding is treated as a fatal error.
                    state_q       <= ST_ERR;
                    mem_timeout_q <= 1'b1;
                end
            endcase
        end
    end

    assign PC_write      = ctl_s.pc_write;
    assign IF_ID_write   = ctl_s.if_id_write;
    assign IF_ID_flush   = ctl_s.if_id_flush;
    assign ID_EX_write   = ctl_s.id_ex_write;
    assign ID_EX_bubble  = ctl_s.id_ex_bubble;
    assign EX_MEM_write  = ctl_s.ex_mem_write;
    assign MEM_WB_bubble = ctl_s.mem_wb_bubble;
    assign mem_timeout   = mem_timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .clear_i (~rst_n),
        .inc_i   (stall_inc_s),
        .count_o (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .clear_i (~rst_n),
        .inc_i   (flush_inc_s),
        .count_o (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Table-driven bench for hazard_stall_controller. Each row is one clock of
// inputs plus the outputs expected at the following negedge; expected rows
// go through a scoreboard queue. A narrow-counter instance on the same
// stimulus checks saturation.
module tb_hazard_stall_controller;

    logic        clk;
    logic        rst_n;
    logic        ID_EX_memRead;
    logic [4:0]  ID_EX_writeReg;
    logic [4:0]  IF_ID_rs;
    logic [4:0]  IF_ID_rt;
    logic        IF_ID_usesRs;
    logic        IF_ID_usesRt;
    logic        EX_branchTaken;
    logic        EX_MEM_memAccess;
    logic        dmem_ready;

    logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_write;
    logic        ID_EX_bubble, EX_MEM_write, MEM_WB_bubble, mem_timeout;
    logic [31:0] stall_count, flush_count;

    logic        s_PC_write, s_IF_ID_write, s_IF_ID_flush, s_ID_EX_write;
    logic        s_ID_EX_bubble, s_EX_MEM_write, s_MEM_WB_bubble, s_mem_timeout;
    logic [2:0]  s_stall_count, s_flush_count;

    int n_vec;
    int n_miss;

    hazard_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_EX_memRead(ID_EX_memRead), .ID_EX_writeReg(ID_EX_writeReg),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
        .IF_ID_usesRs(IF_ID_usesRs), .IF_ID_usesRt(IF_ID_usesRt),
        .EX_branchTaken(EX_branchTaken), .EX_MEM_memAccess(EX_MEM_memAccess),
        .dmem_ready(dmem_ready),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_write(ID_EX_write), .ID_EX_bubble(ID_EX_bubble),
        .EX_MEM_write(EX_MEM_write), .MEM_WB_bubble(MEM_WB_bubble),
        .mem_timeout(mem_timeout), .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .ID_EX_memRead(ID_EX_memRead), .ID_EX_writeReg(ID_EX_writeReg),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
        .IF_ID_usesRs(IF_ID_usesRs), .IF_ID_usesRt(IF_ID_usesRt),
        .EX_branchTaken(EX_branchTaken), .EX_MEM_memAccess(EX_MEM_memAccess),
        .dmem_ready(dmem_ready),
        .PC_write(s_PC_write), .IF_ID_write(s_IF_ID_write), .IF_ID_flush(s_IF_ID_flush),
        .ID_EX_write(s_ID_EX_write), .ID_EX_bubble(s_ID_EX_bubble),
        .EX_MEM_write(s_EX_MEM_write), .MEM_WB_bubble(s_MEM_WB_bubble),
        .mem_timeout(s_mem_timeout), .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic       mr;
        logic [4:0] wr;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic       br;
        logic       ma;
        logic       rdy;
    } in_t;

    // ctl bit order: PC_write, IF_ID_write, IF_ID_flush, ID_EX_write,
    // ID_EX_bubble, EX_MEM_write, MEM_WB_bubble
    typedef struct {
        logic [6:0]  ctl;
        logic        mto;
        logic [31:0] sc;
        logic [31:0] fc;
    } out_t;

    localparam logic [6:0] K_IDLE = 7'b1101010;
    localparam logic [6:0] K_LU   = 7'b0001110;
    localparam logic [6:0] K_BR   = 7'b1111110;
    localparam logic [6:0] K_FRZ  = 7'b0000001;
    localparam logic [6:0] K_RST  = 7'b0011111;

    in_t  tin[$];
    out_t tout[$];
    out_t sb[$];

    function automatic in_t mk(input logic rstn, input logic mr, input logic [4:0] wr,
                               input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt,
                               input logic br, input logic ma, input logic rdy);
        in_t v;
        v.rstn = rstn; v.mr = mr; v.wr = wr; v.rs = rs; v.urs = urs;
        v.rt = rt; v.urt = urt; v.br = br; v.ma = ma; v.rdy = rdy;
        return v;
    endfunction

    function automatic out_t ex(input logic [6:0] ctl, input int sc, input int fc,
                                input logic mto);
        out_t e;
        e.ctl = ctl; e.sc = 32'(sc); e.fc = 32'(fc); e.mto = mto;
        return e;
    endfunction

    task automatic add(input in_t a, input out_t e);
        tin.push_back(a);
        tout.push_back(e);
    endtask

    task automatic drive(input in_t a);
        rst_n            = a.rstn;
        ID_EX_memRead    = a.mr;
        ID_EX_writeReg   = a.wr;
        IF_ID_rs         = a.rs;
        IF_ID_usesRs     = a.urs;
        IF_ID_rt         = a.rt;
        IF_ID_usesRt     = a.urt;
        EX_branchTaken   = a.br;
        EX_MEM_memAccess = a.ma;
        dmem_ready       = a.rdy;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one row, sample at negedge, compare against the scoreboard head.
    task automatic apply(input string tag, input in_t a, input out_t e);
        out_t got;
        drive(a);
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        n_vec++;
        chk({tag, " ctl"}, 32'({PC_write, IF_ID_write, IF_ID_flush, ID_EX_write,
                                ID_EX_bubble, EX_MEM_write, MEM_WB_bubble}), 32'(got.ctl));
        chk({tag, " mem_timeout"}, 32'(mem_timeout), 32'(got.mto));
        chk({tag, " stall_count"}, stall_count, got.sc);
        chk({tag, " flush_count"}, flush_count, got.fc);
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string phase);
        for (int i = 0; i < tin.size(); i++) begin
            apply($sformatf("%s[%0d]", phase, i), tin[i], tout[i]);
        end
        tin.delete();
        tout.delete();
    endtask

    initial begin
        in_t idle_v, lu_v, mw_v;
        n_vec  = 0;
        n_miss = 0;
        idle_v = mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        lu_v   = mk(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        mw_v   = mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        drive(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        repeat (2) @(posedge clk);
        #1;

        // Phase A: basic hazards, memory waits, deferred branch/load-use.
        add(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), ex(K_RST, 0, 0, 1'b0));
        add(idle_v, ex(K_IDLE, 0, 0, 1'b0));
        add(lu_v,   ex(K_LU,   0, 0, 1'b0));
        add(idle_v, ex(K_IDLE, 1, 0, 1'b0));
        add(mk(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), ex(K_IDLE, 1, 0, 1'b0));
        add(mk(1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1), ex(K_LU,   1, 0, 1'b0));
        add(mk(1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1), ex(K_IDLE, 2, 0, 1'b0));
        add(mw_v, ex(K_FRZ, 2, 0, 1'b0));
        add(mw_v, ex(K_FRZ, 3, 0, 1'b0));
        add(mw_v, ex(K_FRZ, 4, 0, 1'b0));
        add(mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1), ex(K_IDLE, 5, 0, 1'b0));
        add(mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), ex(K_BR,   5, 0, 1'b0));
        add(idle_v, ex(K_IDLE, 5, 1, 1'b0));
        add(mk(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), ex(K_BR,   5, 1, 1'b0));
        add(idle_v, ex(K_IDLE, 5, 2, 1'b0));
        add(mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), ex(K_FRZ,  5, 2, 1'b0));
        add(mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), ex(K_FRZ,  6, 2, 1'b0));
        add(mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1), ex(K_BR,   7, 2, 1'b0));
        add(idle_v, ex(K_IDLE, 7, 3, 1'b0));
        add(mk(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), ex(K_FRZ,  7, 3, 1'b0));
        add(mk(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), ex(K_LU,   8, 3, 1'b0));
        add(idle_v, ex(K_IDLE, 9, 3, 1'b0));
        add(lu_v,   ex(K_LU,   9, 3, 1'b0));
        add(idle_v, ex(K_IDLE, 10, 3, 1'b0));
        run_table("A");

        // Narrow counters must have stuck at all-ones (stall) / tracked flushes.
        @(negedge clk);
        n_vec++;
        chk("sat stall_count", 32'(s_stall_count), 32'd7);
        chk("sat flush_count", 32'(s_flush_count), 32'd3);
        chk("wide stall_count", stall_count, 32'd10);
        @(posedge clk);
        #1;

        // Phase B: timeout with dmem_ready held low, ERR stickiness, reset exits.
        for (int i = 0; i < 16; i++) begin
            add(mw_v, ex(K_FRZ, 10 + i, 3, 1'b0));
        end
        add(mw_v, ex(K_FRZ, 26, 3, 1'b1));
        add(mk(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), ex(K_FRZ, 26, 3, 1'b1));
        add(idle_v, ex(K_FRZ, 26, 3, 1'b1));
        add(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), ex(K_RST, 26, 3, 1'b1));
        add(idle_v, ex(K_IDLE, 0, 0, 1'b0));
        // Reset in the middle of a memory wait.
        add(mw_v, ex(K_FRZ, 0, 0, 1'b0));
        add(mw_v, ex(K_FRZ, 1, 0, 1'b0));
        add(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), ex(K_RST, 2, 0, 1'b0));
        add(idle_v, ex(K_IDLE, 0, 0, 1'b0));
        add(lu_v,   ex(K_LU,   0, 0, 1'b0));
        add(idle_v, ex(K_IDLE, 1, 0, 1'b0));
        run_table("B");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Central pipeline sequencer for the 5-stage pipelined core; complements the forwarding logic by handling every hazard forwarding cannot resolve.
- Detects load-use hazards and inserts one bubble.
- Squashes wrong-path instructions on a taken branch resolved in EX.
- Freezes the pipeline while data memory is not ready, with a timeout that latches a fatal error.
- Keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, consecutive not-ready data-memory cycles before fatal error (legal range 2..2^16-1)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
ID_EX_memRead  in  1  instruction in EX is a load
ID_EX_writeReg  in  5  destination register of the instruction in EX
IF_ID_rs  in  5  source register 1 of the instruction in ID
IF_ID_rt  in  5  source register 2 of the instruction in ID
IF_ID_usesRs  in  1  instruction in ID reads rs
IF_ID_usesRt  in  1  instruction in ID reads rt
EX_branchTaken  in  1  branch/jump in EX resolved taken
EX_MEM_memAccess  in  1  instruction in MEM performs a load or store
dmem_ready  in  1  data memory completes the access this cycle
PC_write  out  1  PC register enable
IF_ID_write  out  1  IF/ID register enable
IF_ID_flush  out  1  load NOP into IF/ID
ID_EX_write  out  1  ID/EX register enable
ID_EX_bubble  out  1  load NOP (control bits zero) into ID/EX
EX_MEM_write  out  1  EX/MEM register enable
MEM_WB_bubble  out  1  load NOP into MEM/WB
mem_timeout  out  1  sticky fatal error flag
stall_count  out  CNT_W  load-use plus memory-wait cycles, saturating
flush_count  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Reset: clk and rst_n are as decided above: one clock; reset is synchronous and active-low.
  - Sampled rst_n=0: state<=RUN, wait_cnt<=0, counters<=0, mem_timeout<=0.
  - Reset mid-wait or in ERR: same result, no other effect.
  - While rst_n=0, outputs are forced: PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_write=1, ID_EX_bubble=1, EX_MEM_write=1, MEM_WB_bubble=1.
- Stall/flush outputs are combinational from state and inputs (zero-cycle latency). Counters and mem_timeout are registered.
- Idle defaults: all *_write=1, flush and bubbles=0.
- Conditions:
  - memwait = EX_MEM_memAccess & ~dmem_ready
  - loaduse = ID_EX_memRead & (ID_EX_writeReg!=0) & ((IF_ID_usesRs & IF_ID_rs==ID_EX_writeReg) | (IF_ID_usesRt & IF_ID_rt==ID_EX_writeReg))
- Per-cycle priority: ERR > memwait > branch > loaduse.
- memwait action:
  - PC_write=IF_ID_write=ID_EX_write=EX_MEM_write=0, MEM_WB_bubble=1.
  - A taken branch or load-use present in the same cycle is deferred: the frozen stages re-present it once the wait ends.
- branch action: IF_ID_flush=1, ID_EX_bubble=1, PC_write=1. Any coincident loaduse is ignored.
- loaduse action: PC_write=0, IF_ID_write=0, ID_EX_bubble=1, for exactly one cycle. The bubble clears the condition on the next cycle.
- FSM states:
  - RUN: memwait -> MEM_WAIT with wait_cnt<=1; else stay.
  - MEM_WAIT:
    - dmem_ready=1: that cycle is unfrozen; -> RUN, wait_cnt<=0.
    - else if wait_cnt==MEM_TIMEOUT-1 -> ERR.
    - else wait_cnt++.
    - If EX_MEM_memAccess drops while waiting, treat as ready.
  - ERR: all enables 0, MEM_WB_bubble=1, mem_timeout=1. Exits only by reset.
- Timing consequence: with dmem_ready held low, exactly MEM_TIMEOUT frozen cycles occur, then mem_timeout=1 from the next cycle.
- Counters:
  - stall_count +1 per cycle with a loaduse or memwait action; ERR cycles are not counted.
  - flush_count +1 per branch action.
  - Both saturate at all-ones; no wrap.

Decomposition:
- Shared pipeline package: state encoding (RUN, MEM_WAIT, ERR as 2-bit constants), REG_ADDR_W=5, zero-register constant.
- One natural sub-module: sat_counter (parameter W, inputs inc and clear, saturating), instantiated twice.

Test Plan:
- Reset release with idle inputs -> PC_write=1, all bubbles/flushes 0, counters 0.
- Load in EX with ID_EX_writeReg=5, IF_ID_rs=5, IF_ID_usesRs=1 -> one cycle PC_write=0, IF_ID_write=0, ID_EX_bubble=1; stall_count=1. Repeat with writeReg=0 -> no stall.
- EX_MEM_memAccess=1, dmem_ready low for 3 cycles then high -> 3 frozen cycles with MEM_WB_bubble=1, 4th cycle unfrozen; stall_count=3.
- EX_branchTaken=1 during a 2-cycle memwait -> no flush while frozen; IF_ID_flush=ID_EX_bubble=1 on the release cycle; flush_count=1.
- dmem_ready held low, MEM_TIMEOUT=16 -> 16 frozen cycles, mem_timeout=1 on cycle 17 and held; rst_n=0 for one edge clears it.
- Coincident loaduse and EX_branchTaken -> flush only, no stall; stall_count unchanged.
